multicycle_controller: RTL and testbench

- Multicycle ARM-subset controller: a Moore FSM sequences each instruction over 3-5 cycles on a shared memory/ALU datapath, next generation after the single-cycle decoder.
- Adds a memory-ready handshake, an internal NZCV flag register, condition-code evaluation, negative load/store offsets and an optional EOR ALU code.
- Sits between the instruction register and the multicycle datapath; drives all mux selects and write enables.

---
 rtl/multicycle_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: Moore FSM driving the shared memory/ALU
// datapath, with memory-ready handshake, NZCV flag register and
// condition-code evaluation.
module multicycle_controller #(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [19:0]           Instr,
    input  logic [3:0]            ALUFlags,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic                  RegWrite,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            Flags,
    output logic                  illegal,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_flags;

    // Instruction fields (Instr holds IR[31:12])
    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_rd;
    logic        w_unused;

    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_rd     = Instr[3:0];
    assign w_unused = ^Instr[7:4];

    logic        w_condex;
    logic        w_alu_legal, w_alu_nowrite, w_alu_cv;
    logic [2:0]  w_alu_op;
    logic        w_pcwrite, w_irwrite, w_regwrite, w_memwrite, w_illegal;
    logic [2:0]  w_alucontrol;

    // Condition evaluation against the registered flags; 1111 is never-execute
    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'b0000: w_condex = r_flags[2];
            4'b0001: w_condex = ~r_flags[2];
            4'b0010: w_condex = r_flags[1];
            4'b0011: w_condex = ~r_flags[1];
            4'b0100: w_condex = r_flags[3];
            4'b0101: w_condex = ~r_flags[3];
            4'b0110: w_condex = r_flags[0];
            4'b0111: w_condex = ~r_flags[0];
            4'b1000: w_condex = r_flags[1] & ~r_flags[2];
            4'b1001: w_condex = ~r_flags[1] | r_flags[2];
            4'b1010: w_condex = (r_flags[3] == r_flags[0]);
            4'b1011: w_condex = (r_flags[3] != r_flags[0]);
            4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // Data-processing opcode decode: ALU op, legality, no-writeback and C/V update
    always_comb begin
        w_alu_legal   = 1'b1;
        w_alu_nowrite = 1'b0;
        w_alu_cv      = 1'b0;
        w_alu_op      = 3'b000;
        case (w_funct[4:1])
            4'b0100: begin w_alu_op = 3'b000; w_alu_cv = 1'b1; end
            4'b0010: begin w_alu_op = 3'b001; w_alu_cv = 1'b1; end
            4'b0000: w_alu_op = 3'b010;
            4'b1100: w_alu_op = 3'b011;
            4'b0001: begin
                if (ALU_CTRL_W == 3) w_alu_op = 3'b100;
                else                 w_alu_legal = 1'b0;
            end
            4'b1010: begin w_alu_op = 3'b001; w_alu_nowrite = 1'b1; w_alu_cv = 1'b1; end
            4'b1000: begin w_alu_op = 3'b010; w_alu_nowrite = 1'b1; end
            default: w_alu_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // NZCV capture on the edge leaving EXEC for flag-setting legal ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if ((r_state == S_EXECR || r_state == S_EXECI) &&
                     w_funct[0] && w_alu_legal) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_alu_cv) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Next state and per-state datapath controls
    always_comb begin
        w_next       = r_state;
        w_pcwrite    = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_memwrite   = 1'b0;
        w_illegal    = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        w_alucontrol = 3'b000;
        RegSrc       = {(w_op == 2'b01) && !w_funct[0], 1'b0};
        case (w_op)
            2'b00:   ImmSrc = 2'b00;
            2'b01:   ImmSrc = 2'b01;
            2'b10:   ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!w_condex) w_next = S_FETCH;
                else begin
                    case (w_op)
                        2'b01:   w_next = S_MEMADR;
                        2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   w_next = S_BRANCH;
                        default: begin w_next = S_FETCH; w_illegal = 1'b1; end
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB      = 2'b01;
                w_alucontrol = w_funct[3] ? 3'b000 : 3'b001;
                w_next       = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_pcwrite  = (w_rd == 4'hF);
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alucontrol = w_alu_legal ? w_alu_op : 3'b000;
                w_next       = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB      = 2'b01;
                w_alucontrol = w_alu_legal ? w_alu_op : 3'b000;
                w_next       = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = w_alu_legal && !w_alu_nowrite;
                w_pcwrite  = w_regwrite && (w_rd == 4'hF);
                w_illegal  = !w_alu_legal;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                RegSrc[0] = 1'b1;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Write enables are gated by reset so nothing fires while it is held
    assign PCWrite    = w_pcwrite  & ~reset;
    assign IRWrite    = w_irwrite  & ~reset;
    assign RegWrite   = w_regwrite & ~reset;
    assign MemWrite   = w_memwrite & ~reset;
    assign illegal    = w_illegal  & ~reset & ~(w_unused & 1'b0);
    assign ALUControl = w_alucontrol[ALU_CTRL_W-1:0];
    assign Flags      = r_flags;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one task per scenario, each
// checking state sequence and control outputs against hand-derived values.
module tb_multicycle_controller;

    logic        clk, reset, mem_ready;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags, state;

    logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, ALUSrcA2, RegWrite2, illegal2;
    logic [1:0] ResultSrc2, ALUSrcB2, ImmSrc2, RegSrc2;
    logic [1:0] ALUControl2;
    logic [3:0] Flags2, state2;

    int errs = 0;
    int checks = 0;

    multicycle_controller #(.ALU_CTRL_W(3)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .ALUControl(ALUControl), .Flags(Flags),
        .illegal(illegal), .state(state)
    );

    multicycle_controller #(.ALU_CTRL_W(2)) dut2 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
        .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2),
        .RegSrc(RegSrc2), .RegWrite(RegWrite2), .ALUControl(ALUControl2), .Flags(Flags2),
        .illegal(illegal2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd);
        return {c, op, f, 4'h0, rd};
    endfunction

    // advance one clock; land 2 time units after the rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; Instr = '0; ALUFlags = '0;
        #1;
        checks++; if (state !== 4'd0) begin errs++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (Flags !== 4'b0000) begin errs++; $display("FAIL rst_flags: got %b want 0000", Flags); end
        cyc(); cyc();
        #1;
        checks++; if (PCWrite !== 1'b0) begin errs++; $display("FAIL rst_pcwrite: got %b want 0", PCWrite); end
        checks++; if (IRWrite !== 1'b0) begin errs++; $display("FAIL rst_irwrite: got %b want 0", IRWrite); end
        reset = 1'b0;
        #1;
        checks++; if (IRWrite !== 1'b1) begin errs++; $display("FAIL fetch_irwrite: got %b want 1", IRWrite); end
        checks++; if (PCWrite !== 1'b1) begin errs++; $display("FAIL fetch_pcwrite: got %b want 1", PCWrite); end
    endtask

    task automatic test_add();
        Instr = mk(4'hE, 2'b00, 6'b001000, 4'h1);
        cyc(); #1;
        checks++; if (state !== 4'd1) begin errs++; $display("FAIL add_decode: got %0d want 1", state); end
        checks++; if (ALUSrcB !== 2'd2) begin errs++; $display("FAIL add_decode_srcb: got %0d want 2", ALUSrcB); end
        cyc(); #1;
        checks++; if (state !== 4'd6) begin errs++; $display("FAIL add_execr: got %0d want 6", state); end
        checks++; if (ALUControl !== 3'b000) begin errs++; $display("FAIL add_aluctl: got %b want 000", ALUControl); end
        checks++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL add_exec_regwrite: got %b want 0", RegWrite); end
        checks++; if (ImmSrc !== 2'b00) begin errs++; $display("FAIL add_immsrc: got %b want 00", ImmSrc); end
        cyc(); #1;
        checks++; if (state !== 4'd8) begin errs++; $display("FAIL add_aluwb: got %0d want 8", state); end
        checks++; if (RegWrite !== 1'b1) begin errs++; $display("FAIL add_wb_regwrite: got %b want 1", RegWrite); end
        checks++; if (PCWrite !== 1'b0) begin errs++; $display("FAIL add_wb_pcwrite: got %b want 0", PCWrite); end
        cyc(); #1;
        checks++; if (state !== 4'd0) begin errs++; $display("FAIL add_back_fetch: got %0d want 0", state); end
        checks++; if (Flags !== 4'b0000) begin errs++; $display("FAIL add_flags: got %b want 0000", Flags); end
        // ADD PC, Rn, #imm: immediate path, PC written in writeback
        Instr = mk(4'hE, 2'b00, 6'b101000, 4'hF);
        cyc(); cyc(); #1;
        checks++; if (state !== 4'd7) begin errs++; $display("FAIL addi_execi: got %0d want 7", state); end
        checks++; if (ALUSrcB !== 2'd1) begin errs++; $display("FAIL addi_srcb: got %0d want 1", ALUSrcB); end
        cyc(); #1;
        checks++; if (PCWrite !== 1'b1) begin errs++; $display("FAIL addi_pc_write: got %b want 1", PCWrite); end
        cyc();
    endtask

    task automatic test_flags();
        Instr = mk(4'hE, 2'b00, 6'b000101, 4'h1); ALUFlags = 4'b0110;
        cyc(); cyc(); #1;
        checks++; if (ALUControl !== 3'b001) begin errs++; $display("FAIL subs_aluctl: got %b want 001", ALUControl); end
        cyc(); #1;
        checks++; if (Flags !== 4'b0110) begin errs++; $display("FAIL subs_flags: got %b want 0110", Flags); end
        checks++; if (RegWrite !== 1'b1) begin errs++; $display("FAIL subs_regwrite: got %b want 1", RegWrite); end
        cyc();
        Instr = mk(4'hE, 2'b00, 6'b010101, 4'h0); ALUFlags = 4'b1001;
        cyc(); cyc(); #1;
        checks++; if (ALUControl !== 3'b001) begin errs++; $display("FAIL cmp_aluctl: got %b want 001", ALUControl); end
        cyc(); #1;
        checks++; if (Flags !== 4'b1001) begin errs++; $display("FAIL cmp_flags: got %b want 1001", Flags); end
        checks++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL cmp_regwrite: got %b want 0", RegWrite); end
        cyc();
        // ANDS only touches N and Z; C,V keep 0,1
        Instr = mk(4'hE, 2'b00, 6'b000001, 4'h2); ALUFlags = 4'b0011;
        cyc(); cyc(); cyc(); #1;
        checks++; if (Flags !== 4'b0001) begin errs++; $display("FAIL ands_flags: got %b want 0001", Flags); end
        cyc();
        // VS true with V=1 -> executes
        Instr = mk(4'h6, 2'b00, 6'b001000, 4'h1);
        cyc(); cyc(); #1;
        checks++; if (state !== 4'd6) begin errs++; $display("FAIL vs_taken: got %0d want 6", state); end
        cyc(); cyc();
        // cond 1111 never executes
        Instr = mk(4'hF, 2'b00, 6'b001000, 4'h1);
        cyc(); cyc(); #1;
        checks++; if (state !== 4'd0) begin errs++; $display("FAIL nv_skip: got %0d want 0", state); end
    endtask

    task automatic test_ldr_wait();
        Instr = mk(4'hE, 2'b01, 6'b000001, 4'h2);
        cyc(); cyc(); #1;
        checks++; if (state !== 4'd2) begin errs++; $display("FAIL ldr_memadr: got %0d want 2", state); end
        checks++; if (ALUControl !== 3'b001) begin errs++; $display("FAIL ldr_aluctl: got %b want 001", ALUControl); end
        checks++; if (ImmSrc !== 2'b01) begin errs++; $display("FAIL ldr_immsrc: got %b want 01", ImmSrc); end
        mem_ready = 1'b0;
        cyc(); #1;
        checks++; if (state !== 4'd3 || AdrSrc !== 1'b1) begin errs++; $display("FAIL ldr_memrd1: got st=%0d adr=%b want 3/1", state, AdrSrc); end
        cyc(); #1;
        checks++; if (state !== 4'd3) begin errs++; $display("FAIL ldr_memrd2: got %0d want 3", state); end
        cyc(); #1;
        checks++; if (state !== 4'd3) begin errs++; $display("FAIL ldr_memrd3: got %0d want 3", state); end
        mem_ready = 1'b1;
        cyc(); #1;
        checks++; if (state !== 4'd4 || RegWrite !== 1'b1 || ResultSrc !== 2'd1) begin errs++; $display("FAIL ldr_memwb: got st=%0d rw=%b rs=%0d want 4/1/1", state, RegWrite, ResultSrc); end
        cyc(); #1;
        checks++; if (state !== 4'd0 || RegWrite !== 1'b0) begin errs++; $display("FAIL ldr_done: got st=%0d rw=%b want 0/0", state, RegWrite); end
    endtask

    task automatic test_str_beq();
        Instr = mk(4'hE, 2'b01, 6'b001000, 4'h3);
        cyc(); #1;
        checks++; if (RegSrc !== 2'b10) begin errs++; $display("FAIL str_regsrc: got %b want 10", RegSrc); end
        cyc(); #1;
        checks++; if (ALUControl !== 3'b000) begin errs++; $display("FAIL str_aluctl: got %b want 000", ALUControl); end
        mem_ready = 1'b0;
        cyc(); #1;
        checks++; if (state !== 4'd5 || MemWrite !== 1'b1) begin errs++; $display("FAIL str_memwr1: got st=%0d mw=%b want 5/1", state, MemWrite); end
        cyc(); #1;
        checks++; if (state !== 4'd5 || MemWrite !== 1'b1) begin errs++; $display("FAIL str_memwr2: got st=%0d mw=%b want 5/1", state, MemWrite); end
        mem_ready = 1'b1;
        #1;
        checks++; if (MemWrite !== 1'b1) begin errs++; $display("FAIL str_memwr_rdy: got %b want 1", MemWrite); end
        cyc(); #1;
        checks++; if (state !== 4'd0 || MemWrite !== 1'b0) begin errs++; $display("FAIL str_done: got st=%0d mw=%b want 0/0", state, MemWrite); end
        // BEQ with Z=0 (Flags=0001): not taken
        Instr = mk(4'h0, 2'b10, 6'b000000, 4'h0);
        cyc(); #1;
        checks++; if (state !== 4'd1 || PCWrite !== 1'b0) begin errs++; $display("FAIL beq_decode: got st=%0d pcw=%b want 1/0", state, PCWrite); end
        cyc(); #1;
        checks++; if (state !== 4'd0) begin errs++; $display("FAIL beq_skip: got %0d want 0", state); end
        // BAL: taken
        Instr = mk(4'hE, 2'b10, 6'b000000, 4'h0);
        cyc(); cyc(); #1;
        checks++; if (state !== 4'd9 || PCWrite !== 1'b1) begin errs++; $display("FAIL bal_branch: got st=%0d pcw=%b want 9/1", state, PCWrite); end
        checks++; if (ImmSrc !== 2'b10 || RegSrc !== 2'b01) begin errs++; $display("FAIL bal_sel: got imm=%b rs=%b want 10/01", ImmSrc, RegSrc); end
        cyc();
    endtask

    task automatic test_illegal();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        Instr = mk(4'hE, 2'b11, 6'b000000, 4'h0);
        cyc(); #1;
        checks++; if (state !== 4'd1 || illegal !== 1'b1) begin errs++; $display("FAIL op11_decode: got st=%0d ill=%b want 1/1", state, illegal); end
        cyc(); #1;
        checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errs++; $display("FAIL op11_after: got st=%0d ill=%b want 0/0", state, illegal); end
        // EORS: legal on 3-bit ALUControl, illegal on 2-bit
        Instr = mk(4'hE, 2'b00, 6'b000011, 4'h1); ALUFlags = 4'b1111;
        cyc(); cyc(); #1;
        checks++; if (ALUControl !== 3'b100) begin errs++; $display("FAIL eor_aluctl: got %b want 100", ALUControl); end
        cyc(); #1;
        checks++; if (illegal !== 1'b0 || RegWrite !== 1'b1) begin errs++; $display("FAIL eor3_wb: got ill=%b rw=%b want 0/1", illegal, RegWrite); end
        checks++; if (Flags !== 4'b1100) begin errs++; $display("FAIL eor3_flags: got %b want 1100", Flags); end
        checks++; if (illegal2 !== 1'b1 || RegWrite2 !== 1'b0) begin errs++; $display("FAIL eor2_wb: got ill=%b rw=%b want 1/0", illegal2, RegWrite2); end
        checks++; if (Flags2 !== 4'b0000) begin errs++; $display("FAIL eor2_flags: got %b want 0000", Flags2); end
        cyc(); #1;
        checks++; if (illegal2 !== 1'b0 || state2 !== 4'd0) begin errs++; $display("FAIL eor2_after: got ill=%b st=%0d want 0/0", illegal2, state2); end
    endtask

    task automatic test_reset_abort();
        Instr = mk(4'hE, 2'b01, 6'b001000, 4'h3);
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc(); #1;
        checks++; if (state !== 4'd5 || MemWrite !== 1'b1) begin errs++; $display("FAIL abort_pre: got st=%0d mw=%b want 5/1", state, MemWrite); end
        reset = 1'b1;
        #1;
        checks++; if (MemWrite !== 1'b0) begin errs++; $display("FAIL abort_memwrite: got %b want 0", MemWrite); end
        checks++; if (state !== 4'd0 || Flags !== 4'b0000) begin errs++; $display("FAIL abort_state: got st=%0d fl=%b want 0/0000", state, Flags); end
        mem_ready = 1'b1;
        #1;
        checks++; if (PCWrite !== 1'b0 || IRWrite !== 1'b0) begin errs++; $display("FAIL abort_we: got pcw=%b irw=%b want 0/0", PCWrite, IRWrite); end
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_flags();
        test_ldr_wait();
        test_str_beq();
        test_illegal();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
